// File: rtl/reg_bank_if.sv
// Register bank port bundle: one op-coded write port, two read ports and the
// carry/zero flags that go to the CPU datapath.
interface reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             flag_c;
  logic             flag_z;

  modport master (
    output wr_en, wr_addr, op, data_in, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, flag_c, flag_z
  );

  modport slave (
    input  wr_en, wr_addr, op, data_in, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, flag_c, flag_z
  );
endinterface

// File: rtl/reg_bank.sv
// Multi-mode register bank: DEPTH x WIDTH registers with load/inc/dec/shift/clear
// write port, two combinational read ports (optional bypass) and registered C/Z flags.
module reg_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter bit BYPASS = 1'b1
) (
  input logic         clk_i,
  input logic         rst_ni,
  reg_bank_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_CLR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;

  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             exec;

  assign cur_val = regs_q[bus.wr_addr];

  always_comb begin
    result = cur_val;
    carry  = 1'b0;
    exec   = 1'b0;
    unique case (op_e'(bus.op))
      OP_LOAD: begin
        result = bus.data_in;
        exec   = bus.wr_en;
      end
      OP_INC: begin
        result = cur_val + 1'b1;
        carry  = &cur_val;
        exec   = bus.wr_en;
      end
      OP_DEC: begin
        result = cur_val - 1'b1;
        carry  = ~|cur_val;
        exec   = bus.wr_en;
      end
      OP_SHL: begin
        result = {cur_val[WIDTH-2:0], 1'b0};
        carry  = cur_val[WIDTH-1];
        exec   = bus.wr_en;
      end
      OP_SHR: begin
        result = {1'b0, cur_val[WIDTH-1:1]};
        carry  = cur_val[0];
        exec   = bus.wr_en;
      end
      OP_CLR: begin
        result = '0;
        exec   = bus.wr_en;
      end
      OP_HOLD, OP_RSVD: begin
        exec   = 1'b0;
      end
      default: begin
        exec   = 1'b0;
      end
    endcase
  end

  always_comb begin
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (exec) begin
      flag_c_d = carry;
      flag_z_d = (result == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      if (exec) begin
        regs_q[bus.wr_addr] <= result;
      end
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  // Bypass is gated by reset so a pending write never leaks out while reset holds.
  generate
    if (BYPASS) begin : g_bypass
      logic fwd_a, fwd_b;
      assign fwd_a = exec && rst_ni && (bus.rd_addr_a == bus.wr_addr);
      assign fwd_b = exec && rst_ni && (bus.rd_addr_b == bus.wr_addr);
      assign bus.rd_data_a = fwd_a ? result : regs_q[bus.rd_addr_a];
      assign bus.rd_data_b = fwd_b ? result : regs_q[bus.rd_addr_b];
    end else begin : g_direct
      assign bus.rd_data_a = regs_q[bus.rd_addr_a];
      assign bus.rd_data_b = regs_q[bus.rd_addr_b];
    end
  endgenerate

  assign bus.flag_c = flag_c_q;
  assign bus.flag_z = flag_z_q;

  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;
endmodule

// File: doc/reg_bank.md
# reg_bank

- Parametrised multi-mode register bank: DEPTH registers of WIDTH bits, generalising the single 8-bit load/clear register.
- One write port carries an operation code: load, increment, decrement, shift left, shift right or clear.
- Two combinational read ports, with optional write-to-read bypass.
- Registered carry and zero flags for the CPU datapath; sits between the control unit and the ALU operand muxes.

## Interface

- WIDTH, 8, data width of each register (>= 2)
- DEPTH, 4, number of registers (power of two, >= 2); AW = $clog2(DEPTH)
- BYPASS, 1, 1 = read ports forward the pending write result; 0 = read ports show stored value only

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- wr_en  input  1  write-port enable
- wr_addr  input  AW  target register of the write port
- op  input  3  operation select (see Operation)
- data_in  input  WIDTH  load operand
- rd_addr_a  input  AW  read port A address
- rd_addr_b  input  AW  read port B address
- rd_data_a  output  WIDTH  read port A data (combinational)
- rd_data_b  output  WIDTH  read port B data (combinational)
- flag_c  output  1  registered carry/borrow/shift-out of last executed op
- flag_z  output  1  registered zero flag of last executed op

## Operation

- Reset (rst = 0): all registers, flag_c and flag_z forced to 0 immediately, independent of clk; held while rst = 0.
- Read ports: rd_data_x = reg[rd_addr_x]. Both ports are independent and may address the same register.
- op decode, with R = current reg[wr_addr] and result/carry as follows:
  - 000 HOLD: no write; flags unchanged
  - 001 LOAD: result = data_in; C = 0
  - 010 INC: result = R + 1 modulo 2^WIDTH; C = 1 iff R = all-ones
  - 011 DEC: result = R - 1 modulo 2^WIDTH; C = 1 iff R = 0 (borrow)
  - 100 SHL: result = {R[WIDTH-2:0], 0}; C = R[WIDTH-1]
  - 101 SHR: result = {0, R[WIDTH-1:1]}; C = R[0]
  - 110 CLR: result = 0; C = 0
  - 111 reserved: behaves as HOLD
- Executed op = wr_en = 1 and op in 001..110.
  - On an executed op: reg[wr_addr] <= result; flag_c <= C; flag_z <= (result == 0).
  - Otherwise: no register or flag changes.
- Only reg[wr_addr] changes on a write; all other registers hold.
- Bypass (BYPASS = 1): when an executed op is pending and rd_addr_x = wr_addr, rd_data_x = result (the pre-edge next value). BYPASS = 0: rd_data_x is always the stored value.

## Timing

- Write latency: 1 cycle. The result is visible at the read port from the rising edge on which the op is sampled.
- Flag latency: 1 cycle, same edge as the register update.
- Read latency: 0 cycles (combinational from address; also from data_in and op when bypassing).
- Back-to-back writes to the same register each cycle are legal; each uses the value stored by the previous edge. Example: INC three cycles in a row from 0x00 gives 0x03.
- Reset asserted mid-operation: the pending write is discarded; outputs read 0 within the same cycle.
- Reset release: the first rising edge with rst = 1 executes normally.
- Inputs must be stable around the rising edge. No other handshake; a write is never stalled.

## Test plan

- Reset: load 0x55 into r1, then pull rst low between edges.
  - Required: rd_data_a(r1) = 0x00, flag_c = 0, flag_z = 0 before the next edge.
  - After release, all four registers read 0x00.
- LOAD 0x55 to r1 and 0xAA to r2 on consecutive edges; read A = r1, B = r2.
  - Required: 0x55 / 0xAA, flag_z = 0; r0 and r3 still read 0x00.
- Increment and decrement wrap:
  - LOAD 0xFF to r0, then INC r0: r0 = 0x00, flag_c = 1, flag_z = 1.
  - DEC on r3 = 0x00: r3 = 0xFF, flag_c = 1, flag_z = 0.
- Shifts on r2 = 0x81:
  - SHL: r2 = 0x02, flag_c = 1.
  - Reload 0x81, then SHR: r2 = 0x40, flag_c = 1.
  - SHR of 0x01: r2 = 0x00, flag_c = 1, flag_z = 1.
- Bypass: wr_en = 1, op = LOAD, wr_addr = 3, data_in = 0x3C, rd_addr_a = 3, checked before the edge.
  - Required: rd_data_a = 0x3C with BYPASS = 1; 0x00 with BYPASS = 0.
  - Both configurations read 0x3C after the edge.
- No-op and clear, starting from r1 = 0x55, flag_c = 1:
  - wr_en = 1 with op = 000, then op = 111: r1 stays 0x55 and flags hold.
  - wr_en = 0 with op = CLR: no change.
  - wr_en = 1, op = CLR: r1 = 0x00, flag_c = 0, flag_z = 1.
